// File: rtl/cache_pkg.sv
// Shared cache/memory types, sizes and helpers.
// Used by the main memory controller and its block RAM.
package cache_pkg;

  localparam int ADDR_WIDTH = 12;
  localparam int BLOCK_SIZE = 8;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int OFFSET_WIDTH = clog2(BLOCK_SIZE);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]       addr;
    logic                        cs;
    logic                        rw;
    logic [BLOCK_SIZE-1:0][7:0]  data;
  } memory_request_t;

  typedef struct packed {
    logic                        ack;
    logic [BLOCK_SIZE-1:0][7:0]  data;
  } memory_response_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } mem_state_t;

endpackage

// File: rtl/main_memory_ctrl_ram.sv
// Block-organised byte store with block-wide sync ports.
// Contents survive reset; only the read register clears.
module mem_block_ram #(
  parameter int ADDR_WIDTH = cache_pkg::ADDR_WIDTH,
  parameter int BLOCK_SIZE = cache_pkg::BLOCK_SIZE,
  localparam int IDX_W =
    ADDR_WIDTH - cache_pkg::clog2(BLOCK_SIZE)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we_i,
  input  logic                       re_i,
  input  logic [IDX_W-1:0]           idx_i,
  input  logic [BLOCK_SIZE-1:0][7:0] wdata_i,
  output logic [BLOCK_SIZE-1:0][7:0] rdata_o
);

  localparam int NBLK = 2 ** IDX_W;

  logic [BLOCK_SIZE-1:0][7:0] mem_q [NBLK] = '{default: '0};
  logic [BLOCK_SIZE-1:0][7:0] rdata_q;

  // Whole block written in one edge.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  // Read register holds until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/main_memory_ctrl.sv
// Fixed-latency block memory with four-phase req/ack.
// Requests latched in IDLE; access fires when counter hits 0.
module main_memory_ctrl #(
  parameter int ADDR_WIDTH  = cache_pkg::ADDR_WIDTH,
  parameter int BLOCK_SIZE  = cache_pkg::BLOCK_SIZE,
  parameter int MEM_LATENCY = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  cache_pkg::memory_request_t  mem_req,
  output cache_pkg::memory_response_t mem_resp,
  output logic                        busy
);

  import cache_pkg::*;

  localparam int OFFW  = clog2(BLOCK_SIZE);
  localparam int IDX_W = ADDR_WIDTH - OFFW;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(MEM_LATENCY - 1);

  mem_state_t                 state_q;
  logic [CNT_W-1:0]           cnt_q;
  logic                       ack_q;
  logic                       busy_q;
  logic                       rw_q;
  logic [IDX_W-1:0]           idx_q;
  logic [BLOCK_SIZE-1:0][7:0] wdata_q;
  logic [BLOCK_SIZE-1:0][7:0] rdata;

  logic exec;
  logic ram_we;
  logic ram_re;
  logic unused_offset;

  assign unused_offset = ^mem_req.addr[OFFW-1:0];

  assign exec   = (state_q == ACCESS) && (cnt_q == '0);
  assign ram_we = exec & rw_q & ~reset;
  assign ram_re = exec & ~rw_q & ~reset;

  // Request capture, latency count and ack handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      rw_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mem_req.cs) begin
            idx_q   <= mem_req.addr[ADDR_WIDTH-1:OFFW];
            rw_q    <= mem_req.rw;
            wdata_q <= mem_req.data;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            ack_q   <= 1'b1;
            state_q <= ACK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ACK: begin
          if (!mem_req.cs) begin
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  mem_block_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_ram (
    .clk     (clk),
    .rst     (reset),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata)
  );

  assign mem_resp.ack  = ack_q;
  assign mem_resp.data = rdata;
  assign busy          = busy_q;

endmodule
